// File: rtl/acc_c_responder.sv
// Responder end of the accelerator C-interface.
// Requests pass straight through to an in-order core. The extended ID of each
// write-back request is parked in a small FIFO and re-attached, in order, to
// the core's results. A registered response stage decouples the core from the
// crossbar response channel.
module acc_c_responder #(
    parameter int DataWidth      = 32,
    parameter int NumArgs        = 3,
    parameter int IdWidth        = 2,
    parameter int MaxOutstanding = 4,
    parameter int CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,

    // Crossbar request channel
    input  logic                           q_valid_i,
    output logic                           q_ready_o,
    input  logic [31:0]                    q_instr_i,
    input  logic [NumArgs*DataWidth-1:0]   q_args_i,
    input  logic                           q_wb_i,
    input  logic [IdWidth-1:0]             q_id_i,

    // Core issue channel
    output logic                           issue_valid_o,
    input  logic                           issue_ready_i,
    output logic [31:0]                    issue_instr_o,
    output logic [NumArgs*DataWidth-1:0]   issue_args_o,

    // Core result channel
    input  logic                           res_valid_i,
    output logic                           res_ready_o,
    input  logic [DataWidth-1:0]           res_data_i,
    input  logic                           res_error_i,

    // Crossbar response channel
    output logic                           p_valid_o,
    input  logic                           p_ready_i,
    output logic [DataWidth-1:0]           p_data_o,
    output logic                           p_error_o,
    output logic [IdWidth-1:0]             p_id_o,

    // Status
    output logic [CntWidth-1:0]            outstanding_o,
    output logic                           idle_o
);

    localparam int PtrWidth = $clog2(MaxOutstanding);

    // ID FIFO state
    logic [IdWidth-1:0]  id_mem [MaxOutstanding];
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic [CntWidth-1:0] count;

    logic full;
    logic empty;
    logic stall;
    logic push;
    logic pop;

    // Full/empty come from the registered count only, so a pop never
    // unblocks a push in the same cycle and a push never feeds a same-cycle
    // pop: there is no combinational path between the request and result
    // channels.
    assign full  = (count == CntWidth'(MaxOutstanding));
    assign empty = (count == '0);

    // Only write-back requests need a FIFO slot; plain issues never stall.
    assign stall         = q_wb_i & full;
    assign issue_valid_o = q_valid_i & ~stall;
    assign q_ready_o     = issue_ready_i & ~stall;
    assign issue_instr_o = q_instr_i;
    assign issue_args_o  = q_args_i;

    assign push = q_valid_i & q_ready_o & q_wb_i;

    // A result is taken only when there is an ID to pair it with and the
    // response register is free or draining this cycle.
    assign res_ready_o = ~empty & (~p_valid_o | p_ready_i);
    assign pop         = res_valid_i & res_ready_o;

    assign outstanding_o = count;
    assign idle_o        = empty & ~p_valid_o;

    // ID storage: write the incoming ID at the tail on every push.
    // NOTE: the FIFO array is deliberately not reset; entries are only read
    // behind a valid count, and leaving the reset off keeps it a plain RAM.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem[wr_ptr] <= q_id_i;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    // NOTE: sequential state is always updated with non-blocking assignments so
    // every register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrWidth'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CntWidth'(1);
                2'b01:   count <= count - CntWidth'(1);
                default: count <= count;
            endcase
        end
    end

    // Response register: load on a result handshake, clear once drained, hold otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            p_valid_o <= 1'b0;
            p_data_o  <= '0;
            p_error_o <= 1'b0;
            p_id_o    <= '0;
        end else if (pop) begin
            p_valid_o <= 1'b1;
            p_data_o  <= res_data_i;
            p_error_o <= res_error_i;
            p_id_o    <= id_mem[rd_ptr];
        end else if (p_ready_i) begin
            p_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acc_c_responder.sv
// Self-checking bench for acc_c_responder: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_acc_c_responder;

    localparam int DW   = 32;
    localparam int NA   = 3;
    localparam int IW   = 2;
    localparam int MAXO = 4;
    localparam int CW   = $clog2(MAXO + 1);

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              q_valid_i;
    logic              q_ready_o;
    logic [31:0]       q_instr_i;
    logic [NA*DW-1:0]  q_args_i;
    logic              q_wb_i;
    logic [IW-1:0]     q_id_i;
    logic              issue_valid_o;
    logic              issue_ready_i;
    logic [31:0]       issue_instr_o;
    logic [NA*DW-1:0]  issue_args_o;
    logic              res_valid_i;
    logic              res_ready_o;
    logic [DW-1:0]     res_data_i;
    logic              res_error_i;
    logic              p_valid_o;
    logic              p_ready_i;
    logic [DW-1:0]     p_data_o;
    logic              p_error_o;
    logic [IW-1:0]     p_id_o;
    logic [CW-1:0]     outstanding_o;
    logic              idle_o;

    acc_c_responder #(
        .DataWidth(DW), .NumArgs(NA), .IdWidth(IW), .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .q_valid_i(q_valid_i), .q_ready_o(q_ready_o), .q_instr_i(q_instr_i),
        .q_args_i(q_args_i), .q_wb_i(q_wb_i), .q_id_i(q_id_i),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
        .issue_instr_o(issue_instr_o), .issue_args_o(issue_args_o),
        .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
        .res_data_i(res_data_i), .res_error_i(res_error_i),
        .p_valid_o(p_valid_o), .p_ready_i(p_ready_i), .p_data_o(p_data_o),
        .p_error_o(p_error_o), .p_id_o(p_id_o),
        .outstanding_o(outstanding_o), .idle_o(idle_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: IDs awaiting results, plus the one pending response.
    logic [IW-1:0] m_ids[$];
    bit            m_pv;
    logic [DW-1:0] m_pd;
    bit            m_pe;
    logic [IW-1:0] m_pid;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit qv, input bit wb, input logic [IW-1:0] id, input bit ir,
                         input bit rv, input logic [DW-1:0] rd, input bit re, input bit pr);
        rst_i         = 1'b0;
        q_valid_i     = qv;
        q_wb_i        = wb;
        q_id_i        = id;
        issue_ready_i = ir;
        res_valid_i   = rv;
        res_data_i    = rd;
        res_error_i   = re;
        p_ready_i     = pr;
        q_instr_i     = $urandom;
        q_args_i      = {$urandom, $urandom, $urandom};
    endtask

    task automatic idle_drive();
        drive(0, 0, '0, 1, 0, '0, 0, 1);
    endtask

    // One clock: check combinational outputs before the edge, advance the
    // model at the edge, check registered outputs on the following negedge.
    task automatic cycle();
        bit exp_stall, exp_qr, exp_iv, exp_rr, acc, rhs;
        #1;
        exp_stall = q_wb_i && (m_ids.size() == MAXO);
        exp_qr    = issue_ready_i && !exp_stall;
        exp_iv    = q_valid_i && !exp_stall;
        exp_rr    = (m_ids.size() != 0) && (!m_pv || p_ready_i);
        check("q_ready", q_ready_o, exp_qr);
        check("issue_valid", issue_valid_o, exp_iv);
        check("res_ready", res_ready_o, exp_rr);
        check("issue_instr", issue_instr_o, q_instr_i);
        check("issue_args", issue_args_o, q_args_i);
        acc = q_valid_i && exp_qr;
        rhs = res_valid_i && exp_rr;
        @(posedge clk_i);
        if (rst_i) begin
            m_ids.delete();
            m_pv  = 0;
            m_pd  = '0;
            m_pe  = 0;
            m_pid = '0;
        end else begin
            if (rhs) begin
                m_pid = m_ids.pop_front();
                m_pv  = 1;
                m_pd  = res_data_i;
                m_pe  = res_error_i;
            end else if (m_pv && p_ready_i) begin
                m_pv = 0;
            end
            if (acc && q_wb_i) m_ids.push_back(q_id_i);
        end
        @(negedge clk_i);
        check("p_valid", p_valid_o, m_pv);
        check("p_data", p_data_o, m_pd);
        check("p_error", p_error_o, m_pe);
        check("p_id", p_id_o, m_pid);
        check("outstanding", outstanding_o, m_ids.size());
        check("idle", idle_o, (m_ids.size() == 0) && !m_pv);
    endtask

    initial begin
        idle_drive();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        m_ids.delete();
        m_pv = 0; m_pd = '0; m_pe = 0; m_pid = '0;
        check("rst_p_valid", p_valid_o, 0);
        check("rst_p_data", p_data_o, 0);
        check("rst_p_id", p_id_o, 0);
        check("rst_outstanding", outstanding_o, 0);
        check("rst_idle", idle_o, 1);

        // Single write-back round trip
        drive(1, 1, 2'b10, 1, 0, '0, 0, 1);
        cycle();
        check("single_outst", outstanding_o, 1);
        drive(0, 0, '0, 1, 1, 32'hDEADBEEF, 0, 1);
        cycle();
        check("single_pvalid", p_valid_o, 1);
        check("single_pdata", p_data_o, 32'hDEADBEEF);
        check("single_pid", p_id_o, 2'b10);
        check("single_outst0", outstanding_o, 0);
        idle_drive();
        cycle();
        check("single_idle", idle_o, 1);

        // Fill to capacity
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, IW'(i), 1, 0, '0, 0, 1);
            cycle();
        end
        check("fill_outst", outstanding_o, 4);
        drive(1, 1, 2'd0, 1, 0, '0, 0, 1);
        #1 check("fill_wb_blocked", q_ready_o, 0);
        cycle();
        drive(1, 0, 2'd1, 1, 0, '0, 0, 1);
        #1 check("fill_nowb_ok", q_ready_o, 1);
        cycle();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, '0, 1, 1, 32'hA0 + i, 0, 1);
            cycle();
            check("fill_order_id", p_id_o, i);
            check("fill_order_data", p_data_o, 32'hA0 + i);
        end
        idle_drive();
        cycle();

        // Non-write-back request
        drive(1, 0, 2'd1, 1, 0, '0, 0, 1);
        cycle();
        check("nowb_outst", outstanding_o, 0);
        check("nowb_idle", idle_o, 1);
        idle_drive();
        repeat (2) cycle();

        // Backpressure
        drive(1, 1, 2'd1, 1, 0, '0, 0, 0);
        cycle();
        drive(1, 1, 2'd2, 1, 0, '0, 0, 0);
        cycle();
        drive(0, 0, '0, 1, 1, 32'h11, 1, 0);
        cycle();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, '0, 1, 1, 32'h22, 0, 0);
            cycle();
            check("bp_hold_data", p_data_o, 32'h11);
            check("bp_hold_id", p_id_o, 2'd1);
        end
        drive(0, 0, '0, 1, 1, 32'h22, 0, 1);
        cycle();
        check("bp_b2b_valid", p_valid_o, 1);
        check("bp_b2b_data", p_data_o, 32'h22);
        check("bp_b2b_id", p_id_o, 2'd2);
        idle_drive();
        cycle();

        // Result before ID, then simultaneous push/pop
        drive(0, 0, '0, 1, 1, 32'h33, 0, 1);
        cycle();
        drive(1, 1, 2'd3, 1, 1, 32'h33, 0, 1);
        #1 check("early_res_blocked", res_ready_o, 0);
        cycle();
        drive(0, 0, '0, 1, 1, 32'h33, 0, 1);
        #1 check("early_res_taken", res_ready_o, 1);
        cycle();
        check("early_pid", p_id_o, 2'd3);
        drive(1, 1, 2'd0, 1, 0, '0, 0, 1);
        cycle();
        drive(1, 1, 2'd1, 1, 0, '0, 0, 1);
        cycle();
        drive(1, 1, 2'd2, 1, 1, 32'h44, 0, 1);
        cycle();
        check("pushpop_outst", outstanding_o, 2);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, '0, 1, 1, 32'h50 + i, 0, 1);
            cycle();
        end

        // Reset mid-operation
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, IW'(i), 1, 0, '0, 0, 0);
            cycle();
        end
        drive(0, 0, '0, 1, 1, 32'h66, 0, 0);
        cycle();
        check("pre_rst_pvalid", p_valid_o, 1);
        check("pre_rst_outst", outstanding_o, 3);
        idle_drive();
        rst_i = 1'b1;
        cycle();
        check("post_rst_pvalid", p_valid_o, 0);
        check("post_rst_outst", outstanding_o, 0);
        check("post_rst_idle", idle_o, 1);
        drive(1, 1, 2'd3, 1, 0, '0, 0, 1);
        cycle();
        drive(0, 0, '0, 1, 1, 32'h77, 1, 1);
        cycle();
        check("post_rst_id", p_id_o, 2'd3);
        check("post_rst_data", p_data_o, 32'h77);
        check("post_rst_err", p_error_o, 1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 70, IW'($urandom),
                  $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 55, $urandom,
                  $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 65);
            if ($urandom_range(0, 299) == 0) rst_i = 1'b1;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
